// File: rtl/control_fsm.sv
// LC-3b multicycle control unit: Moore FSM sequencing fetch/decode/execute for
// BR, ADD, AND, NOT, LDR, STR and owning the memory read/write handshake.
module control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       branch_enable,
    input  logic       mem_resp,
    output logic       load_pc,
    output logic       load_ir,
    output logic       load_regfile,
    output logic       load_mar,
    output logic       load_mdr,
    output logic       load_cc,
    output logic       pcmux_sel,
    output logic       storemux_sel,
    output logic       alumux_sel,
    output logic       regfilemux_sel,
    output logic       marmux_sel,
    output logic       mdrmux_sel,
    output logic [2:0] aluop,
    output logic       mem_read,
    output logic       mem_write,
    output logic [1:0] mem_byte_enable
);

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_AND  = 3'd1;
    localparam logic [2:0] ALU_NOT  = 3'd2;
    localparam logic [2:0] ALU_PASS = 3'd3;

    typedef enum logic [3:0] {
        FETCH1, FETCH2, FETCH3, DECODE,
        S_ADD, S_AND, S_NOT, S_BR, S_BR_TAKEN,
        S_CALC_ADDR, S_LDR1, S_LDR2, S_STR1, S_STR2
    } state_t;

    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= FETCH1;
        else
            r_state <= w_next;
    end

    // Next-state: inputs are only looked at in the states that consume them.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            FETCH1: w_next = FETCH2;
            FETCH2: if (mem_resp) w_next = FETCH3;
            FETCH3: w_next = DECODE;
            DECODE: begin
                case (opcode)
                    OP_BR:          w_next = S_BR;
                    OP_ADD:         w_next = S_ADD;
                    OP_AND:         w_next = S_AND;
                    OP_NOT:         w_next = S_NOT;
                    OP_LDR, OP_STR: w_next = S_CALC_ADDR;
                    default:        w_next = FETCH1;
                endcase
            end
            S_ADD, S_AND, S_NOT: w_next = FETCH1;
            S_BR:        w_next = branch_enable ? S_BR_TAKEN : FETCH1;
            S_BR_TAKEN:  w_next = FETCH1;
            S_CALC_ADDR: w_next = (opcode == OP_LDR) ? S_LDR1 : S_STR1;
            S_LDR1:      if (mem_resp) w_next = S_LDR2;
            S_LDR2:      w_next = FETCH1;
            S_STR1:      w_next = S_STR2;
            S_STR2:      if (mem_resp) w_next = FETCH1;
            default:     w_next = FETCH1;
        endcase
    end

    // Output decode depends on r_state only, so no input reaches an output.
    always_comb begin
        load_pc         = 1'b0;
        load_ir         = 1'b0;
        load_regfile    = 1'b0;
        load_mar        = 1'b0;
        load_mdr        = 1'b0;
        load_cc         = 1'b0;
        pcmux_sel       = 1'b0;
        storemux_sel    = 1'b0;
        alumux_sel      = 1'b0;
        regfilemux_sel  = 1'b0;
        marmux_sel      = 1'b0;
        mdrmux_sel      = 1'b0;
        aluop           = ALU_ADD;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 2'b11;
        unique case (r_state)
            FETCH1: begin
                marmux_sel = 1'b1;
                load_mar   = 1'b1;
            end
            FETCH2, S_LDR1: begin
                mem_read   = 1'b1;
                mdrmux_sel = 1'b1;
                load_mdr   = 1'b1;
            end
            FETCH3: begin
                load_ir   = 1'b1;
                load_pc   = 1'b1;
                pcmux_sel = 1'b0;
            end
            S_ADD, S_AND, S_NOT: begin
                aluop          = (r_state == S_AND) ? ALU_AND :
                                 (r_state == S_NOT) ? ALU_NOT : ALU_ADD;
                alumux_sel     = 1'b0;
                regfilemux_sel = 1'b0;
                load_regfile   = 1'b1;
                load_cc        = 1'b1;
            end
            S_BR_TAKEN: begin
                pcmux_sel = 1'b1;
                load_pc   = 1'b1;
            end
            S_CALC_ADDR: begin
                alumux_sel = 1'b1;
                aluop      = ALU_ADD;
                marmux_sel = 1'b0;
                load_mar   = 1'b1;
            end
            S_LDR2: begin
                regfilemux_sel = 1'b1;
                load_regfile   = 1'b1;
                load_cc        = 1'b1;
            end
            S_STR1: begin
                storemux_sel = 1'b1;
                aluop        = ALU_PASS;
                mdrmux_sel   = 1'b0;
                load_mdr     = 1'b1;
            end
            S_STR2: begin
                mem_write    = 1'b1;
                storemux_sel = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
